// File: rtl/servant_uart_loader.sv
// servant_uart_loader: UART boot loader writing a little-endian word image into RAM over Wishbone
module servant_uart_loader #(
  parameter int depth = 256,
  parameter int aw = $clog2(depth),
  parameter int CLKS_PER_BIT = 16
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst_n,
  input  logic          i_rx,
  output logic [aw-1:2] o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_cyc,
  input  logic          i_wb_ack,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_t;
  typedef enum logic [2:0] {HDR0, HDR1, DATA, WRITE, DONE} ld_t;
  logic meta_q, rx_q;
  rx_t rx_st_q, rx_st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d, byte_q, byte_d;
  logic bv_q, bv_d, fe_q, fe_d, err_q, pend_q, pend_d, avail;
  ld_t ld_q, ld_d;
  logic [15:0] rem_q, rem_d;
  logic [1:0] idx_q, idx_d;
  logic [aw-1:2] adr_q, adr_d;
  logic [31:0] word_q, word_d;
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      meta_q <= 1'b1;
      rx_q <= 1'b1;
      rx_st_q <= RX_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      byte_q <= '0;
      bv_q <= 1'b0;
      fe_q <= 1'b0;
      err_q <= 1'b0;
      pend_q <= 1'b0;
      ld_q <= HDR0;
      rem_q <= '0;
      idx_q <= '0;
      adr_q <= '0;
      word_q <= '0;
    end else begin
      meta_q <= i_rx;
      rx_q <= meta_q;
      rx_st_q <= rx_st_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      byte_q <= byte_d;
      bv_q <= bv_d;
      fe_q <= fe_d;
      err_q <= err_q | fe_q;
      pend_q <= pend_d;
      ld_q <= ld_d;
      rem_q <= rem_d;
      idx_q <= idx_d;
      adr_q <= adr_d;
      word_q <= word_d;
    end
  end
  always_comb begin
    rx_st_d = rx_st_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    sh_d = sh_q;
    byte_d = byte_q;
    bv_d = 1'b0;
    fe_d = 1'b0;
    case (rx_st_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx_q) rx_st_d = RX_START;
      end
      RX_START: if (cnt_q == MID) begin
        cnt_d = '0;
        bit_d = '0;
        rx_st_d = rx_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt_q == LAST) begin
        cnt_d = '0;
        sh_d = {rx_q, sh_q[7:1]};
        bit_d = bit_q + 1'b1;
        if (bit_q == 3'd7) rx_st_d = RX_STOP;
      end
      RX_STOP: if (cnt_q == LAST) begin
        cnt_d = '0;
        bv_d = rx_q;
        fe_d = !rx_q;
        byte_d = rx_q ? sh_q : byte_q;
        rx_st_d = RX_WAIT;
      end
      default: begin
        cnt_d = '0;
        if (rx_q) rx_st_d = RX_IDLE;
      end
    endcase
  end
  assign avail = bv_q | pend_q;
  always_comb begin
    ld_d = ld_q;
    rem_d = rem_q;
    idx_d = idx_q;
    adr_d = adr_q;
    word_d = word_q;
    pend_d = (ld_q == WRITE) & (pend_q | bv_q);
    case (ld_q)
      HDR0: if (avail) begin
        rem_d = {8'h00, byte_q};
        ld_d = HDR1;
      end
      HDR1: if (avail) begin
        rem_d = {byte_q, rem_q[7:0]};
        idx_d = '0;
        adr_d = '0;
        ld_d = ({byte_q, rem_q[7:0]} == 16'h0) ? DONE : DATA;
      end
      DATA: if (avail) begin
        word_d[{idx_q, 3'b000} +: 8] = byte_q;
        idx_d = idx_q + 1'b1;
        if (idx_q == 2'd3) ld_d = WRITE;
      end
      WRITE: if (i_wb_ack) begin
        adr_d = adr_q + 1'b1;
        rem_d = rem_q - 16'd1;
        ld_d = (rem_q == 16'd1) ? DONE : DATA;
      end
      default: ;
    endcase
    if (fe_q && ld_q != DONE) begin
      ld_d = HDR0;
      rem_d = '0;
      idx_d = '0;
      adr_d = '0;
      pend_d = 1'b0;
    end
  end
  assign o_wb_adr = adr_q;
  assign o_wb_dat = word_q;
  assign o_wb_cyc = ld_q == WRITE;
  assign o_wb_we = ld_q == WRITE;
  assign o_wb_sel = {4{ld_q == WRITE}};
  assign o_busy = ld_q != DONE;
  assign o_done = ld_q == DONE;
  assign o_err = err_q;
endmodule

// File: tb/tb_servant_uart_loader.sv
// tb_servant_uart_loader: random UART image loads into two loaders (256 B and 16 B RAM) against a word-level model
module tb_servant_uart_loader;
  localparam int CPB = 16;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
  logic [7:2] adr_a;
  logic [3:2] adr_b;
  logic [31:0] dat_a, dat_b;
  logic [3:0] sel_a, sel_b;
  logic we_a, we_b, cyc_a, cyc_b, busy_a, busy_b, done_a, done_b, err_a, err_b;
  logic ack_a = 1'b0, ack_b = 1'b0, done_q = 1'b0;
  logic [31:0] ram_a [64] = '{default: 32'h0};
  logic [31:0] ram_b [4] = '{default: 32'h0};
  logic [31:0] exp_a [64] = '{default: 32'h0};
  logic [31:0] exp_b [4] = '{default: 32'h0};
  int wa_adr[$], wb_adr[$];
  logic [31:0] wa_dat[$], wb_dat[$];
  int ncyc_a = 0, ncyc_b = 0, cycles = 0, done_at = 0, start_at = 0;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  servant_uart_loader #(.depth(256), .CLKS_PER_BIT(CPB)) dut_a (
    .i_wb_clk(clk), .i_wb_rst_n(rst_n), .i_rx(rx), .o_wb_adr(adr_a), .o_wb_dat(dat_a),
    .o_wb_sel(sel_a), .o_wb_we(we_a), .o_wb_cyc(cyc_a), .i_wb_ack(ack_a),
    .o_busy(busy_a), .o_done(done_a), .o_err(err_a));
  servant_uart_loader #(.depth(16), .CLKS_PER_BIT(CPB)) dut_b (
    .i_wb_clk(clk), .i_wb_rst_n(rst_n), .i_rx(rx), .o_wb_adr(adr_b), .o_wb_dat(dat_b),
    .o_wb_sel(sel_b), .o_wb_we(we_b), .o_wb_cyc(cyc_b), .i_wb_ack(ack_b),
    .o_busy(busy_b), .o_done(done_b), .o_err(err_b));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  always @(posedge clk) begin
    cycles <= cycles + 1;
    ack_a <= cyc_a && !ack_a;
    ack_b <= cyc_b && !ack_b;
  end
  always @(negedge clk) begin
    if (cyc_a) ncyc_a <= ncyc_a + 1;
    if (cyc_b) ncyc_b <= ncyc_b + 1;
    if (cyc_a && ack_a) begin
      ram_a[adr_a] <= dat_a;
      wa_adr.push_back(int'(adr_a));
      wa_dat.push_back(dat_a);
      chk("sel_a", 32'(sel_a), 32'hF);
      chk("we_a", 32'(we_a), 1);
    end
    if (cyc_b && ack_b) begin
      ram_b[adr_b] <= dat_b;
      wb_adr.push_back(int'(adr_b));
      wb_dat.push_back(dat_b);
      chk("sel_b", 32'(sel_b), 32'hF);
      chk("we_b", 32'(we_b), 1);
    end
    if (done_a && !done_q) done_at <= cycles;
    done_q <= done_a;
  end
  task automatic send_byte(input logic [7:0] b, input bit stop);
    @(negedge clk);
    rx = 1'b0;
    start_at = cycles;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
  endtask
  task automatic send_bytes(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i], 1'b1);
  endtask
  task automatic glitch();
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB / 2 - 3) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy_a & busy_b), 1);
    chk("rst_err", 32'(err_a | err_b), 0);
    chk("rst_done", 32'(done_a | done_b), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic load(input logic [31:0] w[$]);
    logic [7:0] b[$];
    int ba, bb, ca, cb, n, da, db;
    n = w.size();
    b.push_back(8'(n));
    b.push_back(8'(n >> 8));
    foreach (w[i]) for (int k = 0; k < 4; k++) b.push_back(8'(w[i] >> (8 * k)));
    ba = wa_adr.size();
    bb = wb_adr.size();
    ca = ncyc_a;
    cb = ncyc_b;
    send_bytes(b);
    for (int i = 0; i < 40 && !(done_a && done_b); i++) @(negedge clk);
    chk("done_a", 32'(done_a), 1);
    chk("busy_a", 32'(busy_a), 0);
    chk("done_b", 32'(done_b), 1);
    chk("busy_b", 32'(busy_b), 0);
    chk("nwr_a", wa_adr.size() - ba, n);
    chk("nwr_b", wb_adr.size() - bb, n);
    chk("cyc_len_a", ncyc_a - ca, 2 * n);
    chk("cyc_len_b", ncyc_b - cb, 2 * n);
    for (int i = 0; i < n; i++) begin
      exp_a[i % 64] = w[i];
      exp_b[i % 4] = w[i];
      if (ba + i < wa_adr.size()) begin
        chk("adr_a", wa_adr[ba + i], i % 64);
        chk("dat_a", wa_dat[ba + i], w[i]);
      end
      if (bb + i < wb_adr.size()) begin
        chk("adr_b", wb_adr[bb + i], i % 4);
        chk("dat_b", wb_dat[bb + i], w[i]);
      end
    end
    da = 0;
    db = 0;
    for (int j = 0; j < 64; j++) if (ram_a[j] !== exp_a[j]) da++;
    for (int j = 0; j < 4; j++) if (ram_b[j] !== exp_b[j]) db++;
    chk("ram_a", da, 0);
    chk("ram_b", db, 0);
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] w[$];
    logic [31:0] none[$];
    logic [7:0] bq[$];
    int base, ca, lat;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rx = 1'($urandom);
    end
    chk("r_cyc", 32'(cyc_a | cyc_b), 0);
    chk("r_we", 32'(we_a | we_b), 0);
    chk("r_sel", 32'(sel_a | sel_b), 0);
    chk("r_adr", 32'({adr_a, adr_b}), 0);
    chk("r_dat", dat_a | dat_b, 0);
    chk("r_busy", 32'(busy_a & busy_b), 1);
    chk("r_done", 32'(done_a | done_b), 0);
    chk("r_err", 32'(err_a | err_b), 0);
    rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    ca = ncyc_a;
    repeat (60) @(negedge clk);
    chk("idle_cyc", ncyc_a - ca, 0);
    chk("idle_busy", 32'(busy_a), 1);
    glitch();
    load('{32'h12345678, 32'hDEADBEEF});
    base = wa_adr.size();
    send_byte(8'($urandom), 1'b1);
    chk("ignore_nwr", wa_adr.size() - base, 0);
    chk("ignore_done", 32'(done_a), 1);
    do_reset();
    load(none);
    lat = done_at - start_at;
    chk("n0_lat_ok", 32'(lat >= 150 && lat <= 162), 1);
    send_byte(8'h5A, 1'b0);
    chk("done_fe_err", 32'(err_a & err_b), 1);
    chk("done_fe_done", 32'(done_a), 1);
    do_reset();
    base = wa_adr.size();
    send_bytes('{8'h01, 8'h00, 8'h11});
    send_byte(8'h22, 1'b0);
    chk("fe_err", 32'(err_a & err_b), 1);
    chk("fe_busy", 32'(busy_a), 1);
    chk("fe_nwr", wa_adr.size() - base, 0);
    load('{32'h44332211});
    chk("fe_err_sticky", 32'(err_a), 1);
    do_reset();
    w = {};
    for (int i = 0; i < 5; i++) w.push_back($urandom);
    load(w);
    do_reset();
    base = wa_adr.size();
    bq = '{8'h03, 8'h00, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    fork
      send_bytes(bq);
      begin
        for (int i = 0; i < 2000 && !(cyc_a && !ack_a); i++) @(negedge clk);
        chk("abort_cyc_seen", 32'(cyc_a), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_cyc", 32'(cyc_a | cyc_b), 0);
        chk("abort_busy", 32'(busy_a & busy_b), 1);
        chk("abort_adr", 32'(adr_a), 0);
      end
    join
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("abort_nwr", wa_adr.size() - base, 0);
    load('{$urandom});
    for (int t = 0; t < 4; t++) begin
      do_reset();
      if ($urandom_range(0, 1) == 1) glitch();
      w = {};
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) w.push_back($urandom);
      load(w);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
